// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves complex-ALU control-flow results against
// dispatch-time predictions, raises an oldest-first front-end redirect, and
// buffers every result in a small FIFO drained to the CDB writeback port.
module branch_resolve_unit #(
  parameter int ROB_ID_W   = 6,
  parameter int PREG_W     = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_wr_i,
  input  logic [ROB_ID_W-1:0] pred_rob_id_i,
  input  logic                pred_taken_i,
  input  logic [31:0]         pred_target_i,
  input  logic [31:0]         pred_fallthru_i,
  input  logic                cx_valid_i,
  input  logic [31:0]         cx_result_i,
  input  logic [31:0]         cx_target_i,
  input  logic                cx_taken_i,
  input  logic [ROB_ID_W-1:0] cx_rob_id_i,
  input  logic [PREG_W-1:0]   cx_phys_dest_i,
  input  logic [ROB_ID_W-1:0] rob_head_i,
  input  logic                flush_i,
  output logic                busy_o,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [31:0]         wb_result_o,
  output logic [ROB_ID_W-1:0] wb_rob_id_o,
  output logic [PREG_W-1:0]   wb_phys_dest_o,
  output logic                redirect_o,
  output logic [31:0]         redirect_pc_o,
  output logic [ROB_ID_W-1:0] redirect_rob_id_o,
  output logic                overflow_o
);

  localparam int TBL_N = 1 << ROB_ID_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] BUSY_CNT = (PTR_W+1)'(FIFO_DEPTH-1);

  typedef enum logic {IDLE, PEND} state_t;

  // ---------------- prediction table ----------------
  logic [TBL_N-1:0] tbl_v;
  logic             tbl_taken [TBL_N];
  logic [31:0]      tbl_tgt   [TBL_N];
  logic [31:0]      tbl_ft    [TBL_N];

  // A flush drops anything arriving in the same cycle.
  logic cx_go;
  assign cx_go = cx_valid_i & ~flush_i;

  // Resolve reads the registered table, so a same-cycle write is not seen.
  logic                e_v, e_taken, mispred;
  logic [31:0]         e_tgt, e_ft, fix_pc;
  logic [ROB_ID_W-1:0] cx_age, pend_age;
  assign e_v     = tbl_v[cx_rob_id_i];
  assign e_taken = tbl_taken[cx_rob_id_i];
  assign e_tgt   = tbl_tgt[cx_rob_id_i];
  assign e_ft    = tbl_ft[cx_rob_id_i];
  assign mispred = cx_go & e_v &
                   ((cx_taken_i != e_taken) | (cx_taken_i & (cx_target_i != e_tgt)));
  assign fix_pc  = cx_taken_i ? cx_target_i : e_ft;
  assign cx_age  = cx_rob_id_i - rob_head_i;

  // Valid bits: resolve clears, dispatch sets; the write wins on a tag clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_v <= '0;
    end else if (flush_i) begin
      tbl_v <= '0;
    end else begin
      if (cx_valid_i) tbl_v[cx_rob_id_i]   <= 1'b0;
      if (pred_wr_i)  tbl_v[pred_rob_id_i] <= 1'b1;
    end
  end

  // Prediction payload; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (pred_wr_i && !flush_i) begin
      tbl_taken[pred_rob_id_i] <= pred_taken_i;
      tbl_tgt[pred_rob_id_i]   <= pred_target_i;
      tbl_ft[pred_rob_id_i]    <= pred_fallthru_i;
    end
  end

  // ---------------- redirect FSM ----------------
  state_t state;

  // Redirect on the first mispredict, then only on strictly older ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      redirect_o        <= 1'b0;
      redirect_pc_o     <= '0;
      redirect_rob_id_o <= '0;
      pend_age          <= '0;
    end else begin
      redirect_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else if (mispred && (state == IDLE || cx_age < pend_age)) begin
        state             <= PEND;
        redirect_o        <= 1'b1;
        redirect_pc_o     <= fix_pc;
        redirect_rob_id_o <= cx_rob_id_i;
        pend_age          <= cx_age;
      end
    end
  end

  // ---------------- writeback FIFO ----------------
  logic [31:0]         q_res [FIFO_DEPTH];
  logic [ROB_ID_W-1:0] q_id  [FIFO_DEPTH];
  logic [PREG_W-1:0]   q_pd  [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      cnt;
  logic                full, pop, push;

  assign full   = (cnt == FULL_CNT);
  assign busy_o = (cnt >= BUSY_CNT);
  assign wb_valid_o = (cnt != '0);
  assign pop    = wb_valid_o & wb_ready_i;
  assign push   = cx_go & (~full | pop);

  // Empty FIFO drives zeros so outputs read 0 out of reset.
  assign wb_result_o    = wb_valid_o ? q_res[rd_ptr] : '0;
  assign wb_rob_id_o    = wb_valid_o ? q_id[rd_ptr]  : '0;
  assign wb_phys_dest_o = wb_valid_o ? q_pd[rd_ptr]  : '0;

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (cx_go && full && !pop) overflow_o <= 1'b1;
    end
  end

  // FIFO storage; a full push+pop rewrites the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      q_res[wr_ptr] <= cx_result_i;
      q_id[wr_ptr]  <= cx_rob_id_i;
      q_pd[wr_ptr]  <= cx_phys_dest_i;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_wr_i, pred_taken_i, cx_valid_i, cx_taken_i, flush_i, wb_ready_i;
  logic [5:0]  pred_rob_id_i, cx_rob_id_i, rob_head_i;
  logic [31:0] pred_target_i, pred_fallthru_i, cx_result_i, cx_target_i;
  logic [6:0]  cx_phys_dest_i;
  logic        busy_o, wb_valid_o, redirect_o, overflow_o;
  logic [31:0] wb_result_o, redirect_pc_o;
  logic [5:0]  wb_rob_id_o, redirect_rob_id_o;
  logic [6:0]  wb_phys_dest_o;

  branch_resolve_unit #(.ROB_ID_W(6), .PREG_W(7), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pred_wr_i(pred_wr_i), .pred_rob_id_i(pred_rob_id_i), .pred_taken_i(pred_taken_i),
    .pred_target_i(pred_target_i), .pred_fallthru_i(pred_fallthru_i),
    .cx_valid_i(cx_valid_i), .cx_result_i(cx_result_i), .cx_target_i(cx_target_i),
    .cx_taken_i(cx_taken_i), .cx_rob_id_i(cx_rob_id_i), .cx_phys_dest_i(cx_phys_dest_i),
    .rob_head_i(rob_head_i), .flush_i(flush_i), .busy_o(busy_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_result_o(wb_result_o),
    .wb_rob_id_o(wb_rob_id_o), .wb_phys_dest_o(wb_phys_dest_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .redirect_rob_id_o(redirect_rob_id_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pw; logic [5:0] pid; logic pt; logic [31:0] ptgt, pft;
    logic cv; logic [5:0] cid; logic ct; logic [31:0] ctgt, cres; logic [6:0] cpd;
    logic [5:0] head; logic fl, rdy;
    logic erd; logic [31:0] erpc; logic [5:0] erid;
    logic ewv; logic [5:0] ewid; logic [31:0] ewres; logic [6:0] ewpd;
    logic ebusy, eovf;
  } vec_t;

  vec_t vq[$];
  vec_t cur;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  // Vector builders: P = prediction, C = ALU result, F = flush, H/R sticky head/ready.
  task automatic P(input logic [5:0] id, input logic t, input logic [31:0] tgt, input logic [31:0] ft);
    cur.pw = 1'b1; cur.pid = id; cur.pt = t; cur.ptgt = tgt; cur.pft = ft;
  endtask
  task automatic C(input logic [5:0] id, input logic t, input logic [31:0] tgt,
                   input logic [31:0] res, input logic [6:0] pd);
    cur.cv = 1'b1; cur.cid = id; cur.ct = t; cur.ctgt = tgt; cur.cres = res; cur.cpd = pd;
  endtask
  task automatic F(); cur.fl = 1'b1; endtask
  task automatic H(input logic [5:0] h); cur.head = h; endtask
  task automatic R(input logic r); cur.rdy = r; endtask
  task automatic E(input logic rd, input logic [31:0] rpc, input logic [5:0] rid,
                   input logic wv, input logic [5:0] wid, input logic [31:0] wres,
                   input logic [6:0] wpd, input logic busy, input logic ovf);
    cur.erd = rd; cur.erpc = rpc; cur.erid = rid; cur.ewv = wv; cur.ewid = wid;
    cur.ewres = wres; cur.ewpd = wpd; cur.ebusy = busy; cur.eovf = ovf;
    vq.push_back(cur);
    cur.pw = 1'b0; cur.cv = 1'b0; cur.fl = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    pred_wr_i = v.pw; pred_rob_id_i = v.pid; pred_taken_i = v.pt;
    pred_target_i = v.ptgt; pred_fallthru_i = v.pft;
    cx_valid_i = v.cv; cx_rob_id_i = v.cid; cx_taken_i = v.ct;
    cx_target_i = v.ctgt; cx_result_i = v.cres; cx_phys_dest_i = v.cpd;
    rob_head_i = v.head; flush_i = v.fl; wb_ready_i = v.rdy;
  endtask

  task automatic check_vec(input vec_t v, input int i);
    chk("redirect", i, 32'(redirect_o), 32'(v.erd));
    if (v.erd) begin
      chk("redirect_pc", i, redirect_pc_o, v.erpc);
      chk("redirect_id", i, 32'(redirect_rob_id_o), 32'(v.erid));
    end
    chk("wb_valid", i, 32'(wb_valid_o), 32'(v.ewv));
    if (v.ewv) begin
      chk("wb_rob_id", i, 32'(wb_rob_id_o), 32'(v.ewid));
      chk("wb_result", i, wb_result_o, v.ewres);
      chk("wb_phys_dest", i, 32'(wb_phys_dest_o), 32'(v.ewpd));
    end
    chk("busy", i, 32'(busy_o), 32'(v.ebusy));
    chk("overflow", i, 32'(overflow_o), 32'(v.eovf));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_redirect"}, -1, 32'(redirect_o), 32'd0);
    chk({tag, "_redirect_pc"}, -1, redirect_pc_o, 32'd0);
    chk({tag, "_redirect_id"}, -1, 32'(redirect_rob_id_o), 32'd0);
    chk({tag, "_wb_valid"}, -1, 32'(wb_valid_o), 32'd0);
    chk({tag, "_wb_result"}, -1, wb_result_o, 32'd0);
    chk({tag, "_wb_rob_id"}, -1, 32'(wb_rob_id_o), 32'd0);
    chk({tag, "_wb_phys_dest"}, -1, 32'(wb_phys_dest_o), 32'd0);
    chk({tag, "_busy"}, -1, 32'(busy_o), 32'd0);
    chk({tag, "_overflow"}, -1, 32'(overflow_o), 32'd0);
  endtask

  initial begin
    cur = '{default: '0};
    cur.rdy = 1'b1;

    // T1: correct taken prediction; re-resolve of cleared tag is writeback only
    P(5, 1, 32'h100, 32'h104);                 E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    C(5, 1, 32'h100, 32'h104, 10);             E(0, 0, 0, 1, 5, 32'h104, 10, 0, 0);
                                               E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    C(5, 1, 32'h200, 32'h55, 10);              E(0, 0, 0, 1, 5, 32'h55, 10, 0, 0);
    // T2: predicted not-taken, actually taken
    P(7, 0, 32'h300, 32'h204);                 E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    C(7, 1, 32'h300, 32'h204, 11);             E(1, 32'h300, 7, 1, 7, 32'h204, 11, 0, 0);
                                               E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    F();                                       E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T3: oldest wins, head 0
    P(9, 1, 32'h400, 32'h40);                  E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    P(3, 1, 32'h500, 32'h50);                  E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    P(12, 0, 32'h600, 32'h70);                 E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    C(9, 0, 32'h0, 32'h0, 1);                  E(1, 32'h40, 9, 1, 9, 32'h0, 1, 0, 0);
                                               E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    C(3, 1, 32'h510, 32'h77, 2);               E(1, 32'h510, 3, 1, 3, 32'h77, 2, 0, 0);
                                               E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    C(12, 1, 32'h600, 32'h88, 3);              E(0, 0, 0, 1, 12, 32'h88, 3, 0, 0);
    P(3, 0, 32'h900, 32'h90);                  E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    C(3, 1, 32'h999, 32'h99, 4);               E(0, 0, 0, 1, 3, 32'h99, 4, 0, 0);
    F();                                       E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Age across tag wrap: head 60, tag62 (age 2) older than tag1 (age 5)
    H(60); P(62, 1, 32'hA00, 32'hA04);         E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    P(1, 1, 32'hB00, 32'hB04);                 E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    C(1, 0, 32'h0, 32'h1, 2);                  E(1, 32'hB04, 1, 1, 1, 32'h1, 2, 0, 0);
    C(62, 0, 32'h0, 32'h2, 3);                 E(1, 32'hA04, 62, 1, 62, 32'h2, 3, 0, 0);
    F();                                       E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Same-cycle write + resolve on one tag: resolve sees old, table keeps new
    P(20, 1, 32'hC00, 32'hC04);                E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    P(20, 0, 32'hD00, 32'hD04); C(20, 1, 32'hC00, 32'h5, 6);
                                               E(0, 0, 0, 1, 20, 32'h5, 6, 0, 0);
    C(20, 1, 32'hE00, 32'h6, 7);               E(1, 32'hE00, 20, 1, 20, 32'h6, 7, 0, 0);
    F();                                       E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T5: flush with a same-cycle mispredict, then the old tag is writeback only
    H(0); P(30, 1, 32'h100, 32'h104);          E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    C(30, 0, 32'h0, 32'h7, 8); F();            E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    C(30, 0, 32'h0, 32'h8, 9);                 E(0, 0, 0, 1, 30, 32'h8, 9, 0, 0);
                                               E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T6: LUI result, no prediction
    C(2, 0, 32'h0, 32'h12345000, 5);           E(0, 0, 0, 1, 2, 32'h12345000, 5, 0, 0);
                                               E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T4: backpressure, busy at 3, overflow on 5th push, full push+pop
    R(0); C(40, 0, 0, 32'hA40, 40);            E(0, 0, 0, 1, 40, 32'hA40, 40, 0, 0);
    C(41, 0, 0, 32'hA41, 41);                  E(0, 0, 0, 1, 40, 32'hA40, 40, 0, 0);
    C(42, 0, 0, 32'hA42, 42);                  E(0, 0, 0, 1, 40, 32'hA40, 40, 1, 0);
    C(43, 0, 0, 32'hA43, 43);                  E(0, 0, 0, 1, 40, 32'hA40, 40, 1, 0);
    C(44, 0, 0, 32'hA44, 44);                  E(0, 0, 0, 1, 40, 32'hA40, 40, 1, 1);
    R(1);                                      E(0, 0, 0, 1, 41, 32'hA41, 41, 1, 1);
    C(45, 0, 0, 32'hA45, 45);                  E(0, 0, 0, 1, 42, 32'hA42, 42, 1, 1);
    R(0); C(46, 0, 0, 32'hA46, 46);            E(0, 0, 0, 1, 42, 32'hA42, 42, 1, 1);
    R(1); C(47, 0, 0, 32'hA47, 47);            E(0, 0, 0, 1, 43, 32'hA43, 43, 1, 1);
                                               E(0, 0, 0, 1, 45, 32'hA45, 45, 1, 1);
                                               E(0, 0, 0, 1, 46, 32'hA46, 46, 0, 1);
                                               E(0, 0, 0, 1, 47, 32'hA47, 47, 0, 1);
                                               E(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset state
    rst = 1'b1;
    drive('{default: '0});
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk); #1;
      check_vec(vq[i], i);
    end

    // rst mid-drain: outputs return to zero without waiting for a clock edge
    wb_ready_i = 1'b0; pred_wr_i = 1'b1; pred_rob_id_i = 6'd52; pred_taken_i = 1'b1;
    pred_target_i = 32'h700; pred_fallthru_i = 32'h704;
    cx_valid_i = 1'b1; cx_rob_id_i = 6'd50; cx_taken_i = 1'b0; cx_result_i = 32'h1;
    cx_phys_dest_i = 7'd50;
    @(posedge clk); #1;
    pred_wr_i = 1'b0; cx_rob_id_i = 6'd52; cx_result_i = 32'h2; cx_phys_dest_i = 7'd52;
    @(posedge clk); #1;
    cx_valid_i = 1'b0;
    chk("pre_rst_redirect", -1, 32'(redirect_o), 32'd1);
    chk("pre_rst_wb_valid", -1, 32'(wb_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_wb_valid", -1, 32'(wb_valid_o), 32'd0);
    chk("post_rst_overflow", -1, 32'(overflow_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
